// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin merge of two pixel writers into a FIFO that drains to the frame buffer only during blanking.
// The strobe is registered one edge after the pop; ready is low while the FIFO is full or flushing. Stall counters: FB_ARB_STATS_EN.

module fb_wr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_rdy,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push_vld && !full && !flush;
  assign do_pop  = pop_rdy && !empty && !flush;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module fb_write_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          i_flush,
  input  logic                          i_fetch_next_pixel,
  input  logic                          i_req0_valid,
  input  logic [ADDR_W-1:0]             i_req0_addr,
  input  logic [DATA_W-1:0]             i_req0_data,
  output logic                          o_req0_ready,
  input  logic                          i_req1_valid,
  input  logic [ADDR_W-1:0]             i_req1_addr,
  input  logic [DATA_W-1:0]             i_req1_data,
  output logic                          o_req1_ready,
  output logic                          o_fb_update,
  output logic [ADDR_W-1:0]             o_fb_addr,
  output logic [DATA_W-1:0]             o_fb_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_busy
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]                   o_stall0_cnt,
  output logic [15:0]                   o_stall1_cnt
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef enum logic [1:0] {IDLE, WAIT_BLANK, WRITE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_grant;
  logic          can_grant;
  logic          grant0;
  logic          grant1;
  logic          xfer0;
  logic          xfer1;
  logic          push;
  logic          pop;
  wr_t           push_dat;
  wr_t           head;
  logic [LW-1:0] count;
  logic [LW-1:0] count_nxt;
  logic          full;
  logic          empty;

  // Ready is held low combinationally while reset_ is asserted.
  assign can_grant    = reset_ && !full && !i_flush;
  assign grant0       = i_req0_valid && (!i_req1_valid || last_grant);
  assign grant1       = i_req1_valid && (!i_req0_valid || !last_grant);
  assign o_req0_ready = can_grant && grant0;
  assign o_req1_ready = can_grant && grant1;
  assign xfer0        = i_req0_valid && o_req0_ready;
  assign xfer1        = i_req1_valid && o_req1_ready;
  assign push         = xfer0 || xfer1;
  assign push_dat     = xfer1 ? {i_req1_addr, i_req1_data} : {i_req0_addr, i_req0_data};
  assign pop          = !empty && !i_fetch_next_pixel && !i_flush;

  fb_wr_fifo #(
    .W     ($bits(wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset_),
    .flush    (i_flush),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_rdy  (pop),
    .pop_dat  (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count + LW'(push) - LW'(pop);
    if (i_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (count_nxt != '0) state_nxt = i_fetch_next_pixel ? WAIT_BLANK : WRITE;
        end
        WAIT_BLANK: begin
          if (!i_fetch_next_pixel) state_nxt = (count_nxt == '0) ? IDLE : WRITE;
        end
        WRITE: begin
          if (count_nxt == '0)         state_nxt = IDLE;
          else if (i_fetch_next_pixel) state_nxt = WAIT_BLANK;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      o_fb_update <= 1'b0;
      o_fb_addr   <= '0;
      o_fb_data   <= '0;
    end else begin
      state       <= state_nxt;
      if (push) last_grant <= xfer1;
      // A popped entry always completes its strobe, even if active video resumes.
      o_fb_update <= pop;
      if (pop) begin
        o_fb_addr <= head.addr;
        o_fb_data <= head.data;
      end
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_fifo_level = count;

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      o_stall0_cnt <= '0;
      o_stall1_cnt <= '0;
    end else if (i_flush) begin
      o_stall0_cnt <= '0;
      o_stall1_cnt <= '0;
    end else begin
      if (i_req0_valid && !o_req0_ready && o_stall0_cnt != 16'hFFFF)
        o_stall0_cnt <= o_stall0_cnt + 16'd1;
      if (i_req1_valid && !o_req1_ready && o_stall1_cnt != 16'hFFFF)
        o_stall1_cnt <= o_stall1_cnt + 16'd1;
    end
  end
`else
  // Stall counters are compiled out in this build.
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: arbitration, FIFO drain gating, flush and async reset.
module tb_fb_write_arbiter;
  logic        clk = 1'b0;
  logic        reset_;
  logic        i_flush;
  logic        i_fetch_next_pixel;
  logic        i_req0_valid;
  logic [15:0] i_req0_addr;
  logic [2:0]  i_req0_data;
  logic        o_req0_ready;
  logic        i_req1_valid;
  logic [15:0] i_req1_addr;
  logic [2:0]  i_req1_data;
  logic        o_req1_ready;
  logic        o_fb_update;
  logic [15:0] o_fb_addr;
  logic [2:0]  o_fb_data;
  logic [2:0]  o_fifo_level;
  logic        o_busy;
`ifdef FB_ARB_STATS_EN
  logic [15:0] o_stall0_cnt;
  logic [15:0] o_stall1_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk                (clk),
    .reset_             (reset_),
    .i_flush            (i_flush),
    .i_fetch_next_pixel (i_fetch_next_pixel),
    .i_req0_valid       (i_req0_valid),
    .i_req0_addr        (i_req0_addr),
    .i_req0_data        (i_req0_data),
    .o_req0_ready       (o_req0_ready),
    .i_req1_valid       (i_req1_valid),
    .i_req1_addr        (i_req1_addr),
    .i_req1_data        (i_req1_data),
    .o_req1_ready       (o_req1_ready),
    .o_fb_update        (o_fb_update),
    .o_fb_addr          (o_fb_addr),
    .o_fb_data          (o_fb_data),
    .o_fifo_level       (o_fifo_level),
    .o_busy             (o_busy)
`ifdef FB_ARB_STATS_EN
    ,
    .o_stall0_cnt       (o_stall0_cnt),
    .o_stall1_cnt       (o_stall1_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [15:0] a, input logic [2:0] d);
    i_req0_valid = 1'b1;
    i_req0_addr  = a;
    i_req0_data  = d;
    tick();
    i_req0_valid = 1'b0;
  endtask

  task automatic wr1(input logic [15:0] a, input logic [2:0] d);
    i_req1_valid = 1'b1;
    i_req1_addr  = a;
    i_req1_data  = d;
    tick();
    i_req1_valid = 1'b0;
  endtask

  task automatic chk_strobe(input string tag, input logic [15:0] a, input logic [2:0] d);
    chk({tag, "_upd"}, 32'(o_fb_update), 32'h1);
    chk({tag, "_addr"}, 32'(o_fb_addr), 32'(a));
    chk({tag, "_data"}, 32'(o_fb_data), 32'(d));
  endtask

  logic [15:0] exp_a [4] = '{16'h0200, 16'h0100, 16'h0201, 16'h0101};
  logic [2:0]  exp_d [4] = '{3'b010, 3'b001, 3'b010, 3'b001};

  initial begin
    reset_             = 1'b0;
    i_flush            = 1'b0;
    i_fetch_next_pixel = 1'b0;
    i_req0_valid       = 1'b0;
    i_req0_addr        = '0;
    i_req0_data        = '0;
    i_req1_valid       = 1'b0;
    i_req1_addr        = '0;
    i_req1_data        = '0;

    // Reset state
    #2;
    chk("rst_upd",   32'(o_fb_update),  32'h0);
    chk("rst_addr",  32'(o_fb_addr),    32'h0);
    chk("rst_data",  32'(o_fb_data),    32'h0);
    chk("rst_level", 32'(o_fifo_level), 32'h0);
    chk("rst_busy",  32'(o_busy),       32'h0);
    i_req0_valid = 1'b1;
    #1;
    chk("rst_rdy0", 32'(o_req0_ready), 32'h0);
    i_req0_valid = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
    tick();

    // Single write during blanking: strobe one edge after acceptance
    i_req0_valid = 1'b1;
    i_req0_addr  = 16'h0010;
    i_req0_data  = 3'b101;
    #1;
    chk("t1_rdy0", 32'(o_req0_ready), 32'h1);
    tick();
    i_req0_valid = 1'b0;
    chk("t1_lvl_n",  32'(o_fifo_level), 32'h1);
    chk("t1_upd_n",  32'(o_fb_update),  32'h0);
    chk("t1_busy_n", 32'(o_busy),       32'h1);
    tick();
    chk_strobe("t1_w", 16'h0010, 3'b101);
    chk("t1_lvl_n1", 32'(o_fifo_level), 32'h0);
    tick();
    chk("t1_upd_after", 32'(o_fb_update), 32'h0);
    chk("t1_addr_hold", 32'(o_fb_addr),   32'h0010);
    chk("t1_busy_end",  32'(o_busy),      32'h0);

    // Both requesters valid: grants alternate starting with req1 (req0 went last)
    for (int i = 0; i < 4; i++) begin
      i_req0_valid = 1'b1;
      i_req1_valid = 1'b1;
      i_req0_addr  = 16'h0100 + 16'(i / 2);
      i_req1_addr  = 16'h0200 + 16'((i + 1) / 2);
      i_req0_data  = 3'b001;
      i_req1_data  = 3'b010;
      #1;
      chk("t2_rdy0", 32'(o_req0_ready), 32'(i % 2 == 1));
      chk("t2_rdy1", 32'(o_req1_ready), 32'(i % 2 == 0));
      tick();
      chk("t2_lvl", 32'(o_fifo_level), 32'h1);
      if (i == 0) chk("t2_upd0", 32'(o_fb_update), 32'h0);
      else        chk_strobe("t2_w", exp_a[i-1], exp_d[i-1]);
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tick();
    chk_strobe("t2_last", exp_a[3], exp_d[3]);
    chk("t2_lvl_end", 32'(o_fifo_level), 32'h0);

    // Active video: four accepted, fifth stalls until the first drain
    i_fetch_next_pixel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_req0_valid = 1'b1;
      i_req0_addr  = 16'h0300 + 16'(i);
      i_req0_data  = 3'(i);
      #1;
      chk("t3_rdy_fill", 32'(o_req0_ready), 32'h1);
      tick();
    end
    i_req0_addr = 16'h0304;
    i_req0_data = 3'd4;
    #1;
    chk("t3_rdy_full", 32'(o_req0_ready), 32'h0);
    chk("t3_lvl_full", 32'(o_fifo_level), 32'h4);
    chk("t3_upd_hold", 32'(o_fb_update),  32'h0);
    chk("t3_busy",     32'(o_busy),       32'h1);
    i_fetch_next_pixel = 1'b0;
    tick();
    chk_strobe("t3_w0", 16'h0300, 3'd0);
    chk("t3_lvl_a", 32'(o_fifo_level), 32'h3);
    #1;
    chk("t3_rdy_free", 32'(o_req0_ready), 32'h1);
    tick();
    i_req0_valid = 1'b0;
    chk_strobe("t3_w1", 16'h0301, 3'd1);
    chk("t3_lvl_b", 32'(o_fifo_level), 32'h3);
    for (int j = 2; j < 5; j++) begin
      tick();
      chk_strobe("t3_wj", 16'h0300 + 16'(j), 3'(j));
      chk("t3_lvl_j", 32'(o_fifo_level), 32'(4 - j));
    end
    tick();
    chk("t3_upd_end",  32'(o_fb_update), 32'h0);
    chk("t3_busy_end", 32'(o_busy),      32'h0);

    // Active video resumes after the first pop of three
    i_fetch_next_pixel = 1'b1;
    wr1(16'h0400, 3'b011);
    wr1(16'h0401, 3'b011);
    wr1(16'h0402, 3'b011);
    chk("t4_lvl3", 32'(o_fifo_level), 32'h3);
    chk("t4_busy", 32'(o_busy),       32'h1);
    i_fetch_next_pixel = 1'b0;
    tick();
    i_fetch_next_pixel = 1'b1;
    chk_strobe("t4_w0", 16'h0400, 3'b011);
    chk("t4_lvl2", 32'(o_fifo_level), 32'h2);
    tick();
    chk("t4_upd_blk",  32'(o_fb_update),  32'h0);
    chk("t4_lvl_blk",  32'(o_fifo_level), 32'h2);
    chk("t4_busy_blk", 32'(o_busy),       32'h1);
    i_fetch_next_pixel = 1'b0;
    tick();
    chk_strobe("t4_w1", 16'h0401, 3'b011);
    tick();
    chk_strobe("t4_w2", 16'h0402, 3'b011);
    chk("t4_lvl0", 32'(o_fifo_level), 32'h0);
    tick();
    chk("t4_upd_end",  32'(o_fb_update), 32'h0);
    chk("t4_busy_end", 32'(o_busy),      32'h0);

    // Flush with three queued and a simultaneous request
    i_fetch_next_pixel = 1'b1;
    wr0(16'h0500, 3'b100);
    wr0(16'h0501, 3'b100);
    wr0(16'h0502, 3'b100);
    chk("t5_lvl3", 32'(o_fifo_level), 32'h3);
    i_flush      = 1'b1;
    i_req0_valid = 1'b1;
    i_req0_addr  = 16'h0503;
    #1;
    chk("t5_rdy_flush", 32'(o_req0_ready), 32'h0);
    tick();
    i_flush      = 1'b0;
    i_req0_valid = 1'b0;
    chk("t5_lvl0", 32'(o_fifo_level), 32'h0);
    chk("t5_busy", 32'(o_busy),       32'h0);
    chk("t5_upd",  32'(o_fb_update),  32'h0);
    i_fetch_next_pixel = 1'b0;
    tick();
    chk("t5_upd_a", 32'(o_fb_update), 32'h0);
    tick();
    chk("t5_upd_b", 32'(o_fb_update),  32'h0);
    chk("t5_lvl_b", 32'(o_fifo_level), 32'h0);
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    #1;
    chk("t5_lg_rdy1", 32'(o_req1_ready), 32'h1);
    chk("t5_lg_rdy0", 32'(o_req0_ready), 32'h0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;

    // Asynchronous reset mid-drain, off the clock edge
    i_fetch_next_pixel = 1'b1;
    wr0(16'h0600, 3'b110);
    wr0(16'h0601, 3'b110);
    wr0(16'h0602, 3'b110);
    i_fetch_next_pixel = 1'b0;
    tick();
    chk_strobe("t6_w0", 16'h0600, 3'b110);
    #2;
    reset_ = 1'b0;
    #1;
    chk("t6_upd",  32'(o_fb_update),  32'h0);
    chk("t6_lvl",  32'(o_fifo_level), 32'h0);
    chk("t6_busy", 32'(o_busy),       32'h0);
    chk("t6_addr", 32'(o_fb_addr),    32'h0);
    i_req0_valid = 1'b1;
    #1;
    chk("t6_rdy0", 32'(o_req0_ready), 32'h0);
    i_req0_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_upd_post", 32'(o_fb_update),  32'h0);
      chk("t6_lvl_post", 32'(o_fifo_level), 32'h0);
    end

`ifdef FB_ARB_STATS_EN
    // Ten cycles of req1 stalled behind a full FIFO
    i_fetch_next_pixel = 1'b1;
    wr0(16'h0700, 3'b001);
    wr0(16'h0701, 3'b001);
    wr0(16'h0702, 3'b001);
    wr0(16'h0703, 3'b001);
    i_req1_valid = 1'b1;
    i_req1_addr  = 16'h0710;
    repeat (10) tick();
    i_req1_valid = 1'b0;
    chk("st_stall1", 32'(o_stall1_cnt), 32'd10);
    chk("st_stall0", 32'(o_stall0_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
